// File: rtl/uart_rx_unit_pkg.sv
// Shared UART receive types and constants.
// FSM state encoding, parity modes, minimum bit period.
package uart_rx_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_COMPLETE,
    S_WAIT_IDLE
  } rx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam logic [3:0] MIN_SPEED = 4'd2;

  function automatic logic [3:0] eff_speed(
    input logic [3:0] s
  );
    return (s < MIN_SPEED) ? MIN_SPEED : s;
  endfunction

endpackage

// File: rtl/uart_rx_unit_bit_timer.sv
// Bit-period timer: latches Speed at frame start, counts half then full periods.
// Ports: Clock, Reset, start (load half period), run, speed, tick (sample point).
module uart_rx_bit_timer
  import uart_rx_unit_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       run,
  input  logic [3:0] speed,
  output logic       tick
);

  logic [3:0] nbit;
  logic [3:0] cnt;
  logic [3:0] spd;

  assign spd  = eff_speed(speed);
  assign tick = run && (cnt == 4'd0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      nbit <= MIN_SPEED;
      cnt  <= 4'd0;
    end else if (start) begin
      nbit <= spd;
      cnt  <= (spd >> 1) - 4'd1;
    end else if (run) begin
      if (cnt == 4'd0)
        cnt <= nbit - 4'd1;
      else
        cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/uart_rx_unit.sv
// UART receiver: synchronizes Rx, samples mid-bit, checks parity and stop.
// Ports: Clock, Reset, Rx, Speed, Parity -> Data, DataValid, ParityError, FramingError, Busy.
module uart_rx_unit
  import uart_rx_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Rx,
  input  logic [3:0]            Speed,
  input  logic                  Parity,
  output logic [DATA_WIDTH-1:0] Data,
  output logic                  DataValid,
  output logic                  ParityError,
  output logic                  FramingError,
  output logic                  Busy
);

  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;
  rx_state_t              state;
  rx_state_t              nstate;
  logic [IW-1:0]          bidx;
  logic [DATA_WIDTH-1:0]  shreg;
  logic                   par_q;
  logic                   start;
  logic                   run;
  logic                   tick;
  logic                   par_x;

  assign rxs = sync[SYNC_STAGES-1];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      sync <= '1;
    else
      sync <= {sync[SYNC_STAGES-2:0], Rx};
  end

  uart_rx_bit_timer u_timer (
    .Clock (Clock),
    .Reset (Reset),
    .start (start),
    .run   (run),
    .speed (Speed),
    .tick  (tick)
  );

  assign run = (state == S_START) || (state == S_DATA) ||
               (state == S_PARITY) || (state == S_STOP);

  assign DataValid = (state == S_COMPLETE);
  assign Busy      = (state != S_IDLE);

  // Fold in the received parity bit; nonzero in even mode is an error.
  assign par_x = (^shreg) ^ rxs;

  // COMPLETE also accepts a new start so back-to-back frames at the
  // shortest bit period are not detected one cycle late.
  always_comb begin
    nstate = state;
    start  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rxs) begin
          start  = 1'b1;
          nstate = S_START;
        end
      end
      S_START: begin
        if (tick)
          nstate = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick && (bidx == LAST))
          nstate = S_PARITY;
      end
      S_PARITY: begin
        if (tick)
          nstate = S_STOP;
      end
      S_STOP: begin
        if (tick)
          nstate = S_COMPLETE;
      end
      S_COMPLETE: begin
        if (FramingError) begin
          nstate = S_WAIT_IDLE;
        end else if (!rxs) begin
          start  = 1'b1;
          nstate = S_START;
        end else begin
          nstate = S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (rxs)
          nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      state <= S_IDLE;
    else
      state <= nstate;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bidx  <= '0;
      shreg <= '0;
      par_q <= 1'b0;
    end else if (tick) begin
      unique case (1'b1)
        (state == S_START): bidx <= '0;
        (state == S_DATA): begin
          shreg[bidx] <= rxs;
          bidx        <= bidx + 1'b1;
        end
        (state == S_PARITY):
          par_q <= (Parity == PARITY_EVEN) ? par_x : ~par_x;
        default: ;
      endcase
    end
  end

  // Outputs load on the stop sample so they line up with DataValid.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Data         <= '0;
      ParityError  <= 1'b0;
      FramingError <= 1'b0;
    end else if (tick && (state == S_STOP)) begin
      Data         <= shreg;
      ParityError  <= par_q;
      FramingError <= ~rxs;
    end
  end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Self-checking bench for uart_rx_unit.
// Frames driven serially; expected words queued and checked on DataValid.
module tb_uart_rx_unit;
  import uart_rx_unit_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Rx;
  logic [3:0] Speed;
  logic       Parity;
  logic [8:0] Data;
  logic       DataValid;
  logic       ParityError;
  logic       FramingError;
  logic       Busy;

  uart_rx_unit #(.DATA_WIDTH(9), .SYNC_STAGES(2)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Rx           (Rx),
    .Speed        (Speed),
    .Parity       (Parity),
    .Data         (Data),
    .DataValid    (DataValid),
    .ParityError  (ParityError),
    .FramingError (FramingError),
    .Busy         (Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  typedef struct {
    logic [3:0] spd;
    logic       par;
    logic [8:0] data;
    logic       badpar;
    logic       chg;
    logic       exp_pe;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_strobe = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  always @(negedge Clock) begin
    if (Reset === 1'b0 && DataValid === 1'b1) begin
      n_strobe++;
      if (sbq.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("data", 32'(Data), 32'(mon_e.d));
        chk("parity_err", 32'(ParityError), 32'(mon_e.pe));
        chk("framing_err", 32'(FramingError), 32'(mon_e.fe));
      end
    end
  end

  function automatic logic [11:0] mk_frame(input logic par,
      input logic [8:0] d, input logic badpar);
    logic pb;
    pb = (^d) ^ par ^ badpar;
    return {1'b1, pb, d, 1'b0};
  endfunction

  task automatic send_frame(input logic [3:0] spd, input logic par,
      input logic [8:0] d, input logic badpar, input logic chg);
    logic [11:0] fr;
    int nb;
    nb = (spd < 4'd2) ? 2 : int'(spd);
    fr = mk_frame(par, d, badpar);
    Speed  = spd;
    Parity = par;
    for (int i = 0; i < 12; i++) begin
      Rx = fr[i];
      if (i == 1 && chg) Speed = 4'd9;
      repeat (nb) @(negedge Clock);
    end
    Rx = 1'b1;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while ((sbq.size() != 0 || Busy !== 1'b0) && k < 3000) begin
      @(negedge Clock);
      k++;
    end
    chk(nm, 32'(k < 3000), 32'd1);
    repeat (3) @(negedge Clock);
  endtask

  vec_t vt[7];
  int   s0;
  logic [11:0] fr;

  initial begin
    vt[0] = '{4'd4,  1'b0, 9'h1A5, 1'b0, 1'b0, 1'b0};
    vt[1] = '{4'd15, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0};
    vt[2] = '{4'd15, 1'b1, 9'h000, 1'b1, 1'b0, 1'b1};
    vt[3] = '{4'd0,  1'b0, 9'h155, 1'b0, 1'b0, 1'b0};
    vt[4] = '{4'd1,  1'b1, 9'h0AA, 1'b0, 1'b0, 1'b0};
    vt[5] = '{4'd7,  1'b0, 9'h0F0, 1'b0, 1'b1, 1'b0};
    vt[6] = '{4'd3,  1'b1, 9'h1FF, 1'b1, 1'b0, 1'b1};

    Reset  = 1'b1;
    Rx     = 1'b1;
    Speed  = 4'd4;
    Parity = 1'b0;
    repeat (3) @(negedge Clock);
    chk("rst_data", 32'(Data), 32'd0);
    chk("rst_valid", 32'(DataValid), 32'd0);
    chk("rst_perr", 32'(ParityError), 32'd0);
    chk("rst_ferr", 32'(FramingError), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    Reset = 1'b0;
    repeat (4) @(negedge Clock);

    for (int i = 0; i < 7; i++) begin
      sbq.push_back('{vt[i].data, vt[i].exp_pe, 1'b0});
      send_frame(vt[i].spd, vt[i].par, vt[i].data, vt[i].badpar, vt[i].chg);
      wait_done($sformatf("vec%0d_timeout", i));
    end

    s0 = n_strobe;
    sbq.push_back('{9'h155, 1'b0, 1'b0});
    sbq.push_back('{9'h0AA, 1'b0, 1'b0});
    send_frame(4'd2, 1'b0, 9'h155, 1'b0, 1'b0);
    send_frame(4'd2, 1'b0, 9'h0AA, 1'b0, 1'b0);
    wait_done("b2b_timeout");
    chk("b2b_strobes", 32'(n_strobe - s0), 32'd2);

    s0 = n_strobe;
    Speed = 4'd8;
    Rx = 1'b0;
    @(negedge Clock);
    Rx = 1'b1;
    repeat (2) @(negedge Clock);
    chk("glitch_busy_hi", 32'(Busy), 32'd1);
    repeat (4) @(negedge Clock);
    chk("glitch_busy_lo", 32'(Busy), 32'd0);
    chk("glitch_data", 32'(Data), 32'h0AA);
    repeat (20) @(negedge Clock);
    chk("glitch_no_strobe", 32'(n_strobe - s0), 32'd0);

    s0 = n_strobe;
    Speed  = 4'd5;
    Parity = 1'b0;
    fr = mk_frame(1'b0, 9'h1FF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      Rx = fr[i];
      repeat (5) @(negedge Clock);
    end
    Rx = fr[5];
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("mid_rst_data", 32'(Data), 32'd0);
    chk("mid_rst_valid", 32'(DataValid), 32'd0);
    chk("mid_rst_perr", 32'(ParityError), 32'd0);
    chk("mid_rst_ferr", 32'(FramingError), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    Rx = 1'b1;
    repeat (60) @(negedge Clock);
    chk("rst_no_strobe", 32'(n_strobe - s0), 32'd0);
    chk("rst_idle", 32'(Busy), 32'd0);
    sbq.push_back('{9'h0F3, 1'b0, 1'b0});
    send_frame(4'd5, 1'b0, 9'h0F3, 1'b0, 1'b0);
    wait_done("post_rst_timeout");

    s0 = n_strobe;
    Speed  = 4'd6;
    Parity = 1'b0;
    sbq.push_back('{9'h000, 1'b0, 1'b1});
    Rx = 1'b0;
    repeat (3 * 12 * 6) @(negedge Clock);
    chk("break_busy", 32'(Busy), 32'd1);
    chk("break_strobes", 32'(n_strobe - s0), 32'd1);
    Rx = 1'b1;
    repeat (4) @(negedge Clock);
    chk("break_release", 32'(Busy), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
